// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: DATA register feeds a small byte FIFO, an 8N1 serialiser drains it.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr_i,
   input  logic [31:0] wd_i,
   input  logic        we_i,
   input  logic [4:0]  memi_i,
   output logic [31:0] rd_o,
   output logic        sel_o,
   output logic        tx_o,
   output logic        irq_o
);

   localparam int          PTR_W       = $clog2(FIFO_DEPTH);
   localparam int          CNT_W       = PTR_W + 1;
   localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
   localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   localparam logic PARITY_FLAG = 1'b1;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
   localparam logic PARITY_FLAG = 1'b0;
`endif

   state_t           state;
   state_t           state_next;
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic [7:0]       shift_byte;
   logic [15:0]      baud_cnt;
   logic [15:0]      baud_next;
   logic [2:0]       bit_cnt;
   logic [2:0]       bit_next;
   logic             tx_q;
   logic             tx_next;

   logic fifo_full;
   logic fifo_empty;
   logic push_req;
   logic clear_req;
   logic pop;
   logic push;
   logic overflow_evt;
   logic baud_done;
   logic busy;
   logic [31:0] status_word;
   logic unused_bus;

   assign fifo_full    = (count == DEPTH_CNT);
   assign fifo_empty   = (count == '0);
   assign push_req     = we_i && (addr_i == BASE_ADDR);
   assign clear_req    = we_i && (addr_i == STATUS_ADDR) && wd_i[3];
   assign pop          = (state == S_IDLE) && !fifo_empty;
   // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
   assign push         = push_req && (!fifo_full || pop);
   assign overflow_evt = push_req && fifo_full && !pop;
   assign baud_done    = (baud_cnt == BAUD_LAST);
   assign busy         = (state != S_IDLE);
   assign unused_bus   = ^{memi_i, wd_i[31:8]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= wd_i[7:0];
      end
   end

   // Overflow is sticky; a drop on the same edge as a clear keeps it set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (overflow_evt) begin
         overflow <= 1'b1;
      end else if (clear_req) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         tx_q     <= 1'b1;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_next;
         bit_cnt  <= bit_next;
         tx_q     <= tx_next;
      end
   end

   always_ff @(posedge clk) begin
      if (pop) begin
         shift_byte <= fifo_mem[rd_ptr];
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_next = S_START;
            end
         end
         S_START: begin
            if (baud_done) begin
               state_next = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_done && (bit_cnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               state_next = S_PARITY;
`else
               state_next = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_done) begin
               state_next = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (baud_done) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // The line value is computed for the coming cycle and registered, so tx_o never glitches.
   always_comb begin
      baud_next = baud_cnt + 16'd1;
      bit_next  = bit_cnt;
      tx_next   = 1'b1;
      if ((state_next != state) || (state == S_IDLE) || baud_done) begin
         baud_next = '0;
      end
      if (state_next == S_DATA) begin
         if ((state == S_DATA) && baud_done) begin
            bit_next = bit_cnt + 3'd1;
         end
      end else begin
         bit_next = '0;
      end
      case (state_next)
         S_START:  tx_next = 1'b0;
         S_DATA:   tx_next = shift_byte[bit_next];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_next = ^shift_byte;
`endif
         default:  tx_next = 1'b1;
      endcase
   end

   always_comb begin
      status_word        = '0;
      status_word[0]     = fifo_full;
      status_word[1]     = fifo_empty;
      status_word[2]     = busy;
      status_word[3]     = overflow;
      status_word[4]     = PARITY_FLAG;
      status_word[15:8]  = {{(8 - CNT_W){1'b0}}, count};
   end

   assign sel_o = (addr_i == BASE_ADDR) || (addr_i == STATUS_ADDR);
   assign rd_o  = (addr_i == STATUS_ADDR) ? status_word : 32'd0;
   assign tx_o  = tx_q;
   assign irq_o = fifo_empty && !busy;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a cycle-level model of FIFO/transmitter timing checks STATUS, irq and
// the line every cycle, while a serial-line monitor decodes frames and pops expected bytes from a queue.
module tb_mmio_uart_tx;

   localparam int          CPB   = 4;
   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef UART_TX_PARITY_EN
   localparam int   FRAME = 11;
   localparam logic PAR   = 1'b1;
`else
   localparam int   FRAME = 10;
   localparam logic PAR   = 1'b0;
`endif

   logic        clk  = 1'b0;
   logic        rst  = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wd   = 32'd0;
   logic        we   = 1'b0;
   logic [4:0]  memi = 5'd0;
   logic [31:0] rd;
   logic        sel;
   logic        tx;
   logic        irq;

   int         vectors    = 0;
   int         miscompares = 0;
   logic [7:0] exp_q [$];
   logic [7:0] mq [$];
   logic       ovf_m      = 1'b0;
   int         cyc        = 0;
   int         busy_end   = 0;
   int         frame_start = 0;
   logic [7:0] cur_byte   = 8'd0;

   always #5 clk = ~clk;

   mmio_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .BASE_ADDR    (BASE)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .addr_i (addr),
      .wd_i   (wd),
      .we_i   (we),
      .memi_i (memi),
      .rd_o   (rd),
      .sel_o  (sel),
      .tx_o   (tx),
      .irq_o  (irq)
   );

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeoutFail(input string name);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   function automatic logic [31:0] modelStatus();
      logic [31:0] s;
      s       = 32'd0;
      s[0]    = (mq.size() == DEPTH);
      s[1]    = (mq.size() == 0);
      s[2]    = (cyc < busy_end);
      s[3]    = ovf_m;
      s[4]    = PAR;
      s[15:8] = 8'(mq.size());
      return s;
   endfunction

   // Serial line after edge cyc: start bit, data LSB first, optional parity, then high.
   function automatic logic modelTx();
      int k;
      if (cyc >= busy_end) return 1'b1;
      k = (cyc - frame_start) / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return cur_byte[k-1];
      if (PAR && (k == 9)) return ^cur_byte;
      return 1'b1;
   endfunction

   task automatic checkOutput();
      we   = 1'b0;
      addr = BASE + 32'd4;
      #1;
      compare("status", rd, modelStatus());
      compare("irq", {31'd0, irq}, {31'd0, (mq.size() == 0) && (cyc >= busy_end)});
      compare("tx", {31'd0, tx}, {31'd0, modelTx()});
   endtask

   task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d);
      logic pop_m, push_req, clr, full;
      we   = w;
      addr = a;
      wd   = d;
      memi = 5'($urandom);
      #1;
      compare("sel", {31'd0, sel}, {31'd0, (a == BASE) || (a == BASE + 32'd4)});
      compare("rd", rd, (a == BASE + 32'd4) ? modelStatus() : 32'd0);
      pop_m    = (cyc >= busy_end) && (mq.size() > 0);
      push_req = w && (a == BASE);
      clr      = w && (a == BASE + 32'd4) && d[3];
      full     = (mq.size() == DEPTH);
      if (pop_m) begin
         cur_byte    = mq.pop_front();
         frame_start = cyc + 1;
         busy_end    = cyc + 1 + FRAME * CPB;
      end
      if (push_req && (!full || pop_m)) begin
         mq.push_back(d[7:0]);
         exp_q.push_back(d[7:0]);
      end else if (push_req) begin
         ovf_m = 1'b1;
      end else if (clr) begin
         ovf_m = 1'b0;
      end
      @(posedge clk);
      cyc++;
      #1;
      checkOutput();
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, BASE + 32'd8, $urandom);
   endtask

   task automatic drain(input string name);
      int g;
      g = 0;
      while (((mq.size() != 0) || (cyc < busy_end)) && (g < 2000)) begin
         idle(1);
         g++;
      end
      if (g >= 2000) timeoutFail(name);
      idle(4);
      compare({name, " scoreboard empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: decode each frame from the line, mid-bit sampled, and score it against the queue.
   initial begin
      int         k;
      int         j;
      logic       active;
      logic [7:0] b;
      logic [7:0] e;
      active = 1'b0;
      k      = 0;
      b      = 8'd0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            active = 1'b0;
         end else if (!active) begin
            if (tx == 1'b0) begin
               active = 1'b1;
               k      = 0;
            end
         end else begin
            k++;
            if ((k % CPB) == (CPB / 2)) begin
               j = k / CPB;
               if (j == 0) begin
                  compare("start bit", {31'd0, tx}, 32'd0);
               end else if (j <= 8) begin
                  b[j-1] = tx;
               end else if (j == FRAME - 1) begin
                  compare("stop bit", {31'd0, tx}, 32'd1);
                  if (exp_q.size() == 0) begin
                     vectors++;
                     miscompares++;
                     $display("[TB] FAIL unexpected frame: got 0x%02h, want none at %0t", b, $time);
                  end else begin
                     e = exp_q.pop_front();
                     compare("frame byte", {24'd0, b}, {24'd0, e});
                  end
                  active = 1'b0;
               end else begin
                  compare("parity bit", {31'd0, tx}, {31'd0, ^b});
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int g;
      int r;
      // Reset state, observed while reset is held.
      addr = BASE + 32'd4;
      #12;
      compare("reset tx", {31'd0, tx}, 32'd1);
      compare("reset irq", {31'd0, irq}, 32'd1);
      compare("reset status", rd, PAR ? 32'h0000_0012 : 32'h0000_0002);
      #10;
      rst = 1'b1;

      // Address decode.
      applyStimulus(1'b0, BASE + 32'd8, 32'hFFFF_FFFF);
      applyStimulus(1'b0, BASE, 32'd0);

      // Single byte, full frame timing checked cycle by cycle.
      applyStimulus(1'b1, BASE, 32'hFFFF_FFA5);
      idle(FRAME * CPB + 6);
      compare("A5 scoreboard empty", 32'(exp_q.size()), 32'd0);

      // Six back-to-back writes from idle: one popped, four queued, one dropped.
      for (int i = 1; i <= 6; i++) applyStimulus(1'b1, BASE, 32'(i));
      compare("burst count", {24'd0, rd[15:8]}, 32'd4);
      compare("burst overflow", {31'd0, rd[3]}, 32'd1);
      compare("burst full", {31'd0, rd[0]}, 32'd1);
      applyStimulus(1'b1, BASE + 32'd4, 32'h0000_0008);
      compare("overflow cleared", {31'd0, rd[3]}, 32'd0);

      // Write into a full FIFO on the very edge the transmitter pops.
      g = 0;
      while ((cyc < busy_end) && (g < 200)) begin
         idle(1);
         g++;
      end
      if (g >= 200) timeoutFail("pop edge wait");
      applyStimulus(1'b1, BASE, 32'h0000_0077);
      compare("pop-edge count", {24'd0, rd[15:8]}, 32'd4);
      compare("pop-edge overflow", {31'd0, rd[3]}, 32'd0);
      drain("burst");

      // Randomised traffic mixing data writes, status writes and stray accesses.
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: applyStimulus(1'b1, BASE, $urandom);
            3:       applyStimulus(1'b1, BASE + 32'd4, $urandom);
            4:       applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom);
            5:       applyStimulus(1'b0, BASE + 32'd4, $urandom);
            default: idle(1);
         endcase
      end
      drain("random");

      // Reset in the middle of data bit 3 of an all-zero byte.
      applyStimulus(1'b1, BASE, 32'h0000_0000);
      idle(1);
      g = 0;
      while ((cyc < frame_start + 17) && (g < 100)) begin
         idle(1);
         g++;
      end
      if (g >= 100) timeoutFail("bit3 wait");
      compare("line low in bit 3", {31'd0, tx}, 32'd0);
      #1;
      rst = 1'b0;
      #1;
      compare("tx on reset", {31'd0, tx}, 32'd1);
      compare("irq on reset", {31'd0, irq}, 32'd1);
      mq.delete();
      exp_q.delete();
      ovf_m    = 1'b0;
      busy_end = cyc;
      idle(2);
      rst = 1'b1;
      addr = BASE + 32'd4;
      #1;
      compare("status after reset", rd, PAR ? 32'h0000_0012 : 32'h0000_0002);
      idle(80);
      compare("final scoreboard empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
